// File: rtl/panel_scanner.sv
// Front-panel readout engine: walks the register-select index, captures each console
// word and shifts it MSB-first into a 74x595 chain, then pulses the chain latch once.
module panel_scanner #(
   parameter int NREGS = 8,
   parameter int DIV   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        scan_en,
   input  logic [15:0] qc_in,
   output logic [3:0]  sel,
   output logic        sclk,
   output logic        sdata,
   output logic        slatch,
   output logic        busy,
   output logic        frame_done
);

   localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [3:0]    SEL_LAST = 4'(NREGS - 1);

   typedef enum logic [2:0] {IDLE, SELECT, CAPTURE, SHIFT, NEXT, LATCH, DONE} state_t;

   state_t        state;
   logic [15:0]   shreg;
   logic [3:0]    bitcnt;
   logic [DW-1:0] divcnt;

   // Sixteen left shifts empty the register, so sdata is 0 outside SHIFT for free.
   assign sdata = shreg[15];

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         divcnt     <= '0;
         sel        <= '0;
         sclk       <= 1'b0;
         slatch     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (scan_en) begin
                  state <= SELECT;
                  busy  <= 1'b1;
                  sel   <= '0;
               end
            end
            SELECT: state <= CAPTURE;
            CAPTURE: begin
               shreg  <= qc_in;
               bitcnt <= '0;
               divcnt <= '0;
               sclk   <= 1'b0;
               state  <= SHIFT;
            end
            SHIFT: begin
               if (divcnt != DIV_LAST) begin
                  divcnt <= divcnt + 1'b1;
               end else begin
                  divcnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else begin
                     // end of the high phase: next bit appears with the falling edge
                     sclk   <= 1'b0;
                     shreg  <= {shreg[14:0], 1'b0};
                     bitcnt <= bitcnt + 4'd1;
                     if (bitcnt == 4'd15) state <= NEXT;
                  end
               end
            end
            NEXT: begin
               if (sel == SEL_LAST) begin
                  slatch <= 1'b1;
                  divcnt <= '0;
                  state  <= LATCH;
               end else begin
                  sel   <= sel + 4'd1;
                  state <= SELECT;
               end
            end
            LATCH: begin
               if (divcnt != DIV_LAST) begin
                  divcnt <= divcnt + 1'b1;
               end else begin
                  slatch     <= 1'b0;
                  frame_done <= 1'b1;
                  sel        <= '0;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (scan_en) begin
                  state <= SELECT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_panel_scanner.sv
// Directed bench for panel_scanner: three instances (defaults, NREGS=2/DIV=1, NREGS=2/DIV=3)
// exercised with a vector table plus hand-written frame, drop-out and reset sequences.
module tb_panel_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   total = 0, bad = 0, cyc = 0;
   bit   mon_on = 1'b0;

   always @(posedge clk) cyc++;

   logic        d_scan, s_scan, t_scan;
   logic [15:0] d_qc, s_qc, t_qc;
   logic [3:0]  d_sel, s_sel, t_sel;
   logic        d_sclk, d_sdata, d_slatch, d_busy, d_fd;
   logic        s_sclk, s_sdata, s_slatch, s_busy, s_fd;
   logic        t_sclk, t_sdata, t_slatch, t_busy, t_fd;

   // external console muxes
   assign d_qc = {12'h100, d_sel};
   assign t_qc = (t_sel == 4'd0) ? 16'hC0DE : 16'h3F01;

   panel_scanner u_d (.clock(clk), .reset(reset), .scan_en(d_scan), .qc_in(d_qc), .sel(d_sel),
      .sclk(d_sclk), .sdata(d_sdata), .slatch(d_slatch), .busy(d_busy), .frame_done(d_fd));
   panel_scanner #(.NREGS(2), .DIV(1)) u_s (.clock(clk), .reset(reset), .scan_en(s_scan),
      .qc_in(s_qc), .sel(s_sel), .sclk(s_sclk), .sdata(s_sdata), .slatch(s_slatch),
      .busy(s_busy), .frame_done(s_fd));
   panel_scanner #(.NREGS(2), .DIV(3)) u_t (.clock(clk), .reset(reset), .scan_en(t_scan),
      .qc_in(t_qc), .sel(t_sel), .sclk(t_sclk), .sdata(t_sdata), .slatch(t_slatch),
      .busy(t_busy), .frame_done(t_fd));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Edge-discipline monitors: sdata must hold while sclk is high, idle outputs all zero.
   logic t_psclk = 1'b0;
   logic [31:0] t_stream = '0;
   int t_hirun = 0, t_lorun = 0, t_badhi = 0, t_lo3 = 0, t_nhi = 0;
   int glitch = 0, idlebad = 0;
   logic d_ps = 1'b0, s_ps = 1'b0, d_pd = 1'b0, s_pd = 1'b0, t_pd = 1'b0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (t_sclk) begin
            if (!t_psclk) begin
               if (t_lorun == 3) t_lo3++;
               t_nhi++;
               t_stream = {t_stream[30:0], t_sdata};
               t_hirun  = 0;
            end
            t_hirun++;
         end else begin
            if (t_psclk) begin
               if (t_hirun != 3) t_badhi++;
               t_lorun = 0;
            end
            t_lorun++;
         end
         if ((d_ps && d_sclk && d_sdata !== d_pd) || (s_ps && s_sclk && s_sdata !== s_pd) ||
             (t_psclk && t_sclk && t_sdata !== t_pd)) glitch++;
         if ((!d_busy && {d_sel, d_sclk, d_sdata, d_slatch, d_fd} != 8'd0) ||
             (!s_busy && {s_sel, s_sclk, s_sdata, s_slatch, s_fd} != 8'd0) ||
             (!t_busy && {t_sel, t_sclk, t_sdata, t_slatch, t_fd} != 8'd0)) idlebad++;
      end
      t_psclk = t_sclk; d_ps = d_sclk; s_ps = s_sclk;
      t_pd = t_sdata; d_pd = d_sdata; s_pd = s_sdata;
   end

   typedef struct {
      logic [15:0] w0;
      logic [15:0] w1;
      bit          noise;
      logic [31:0] stream;
   } vec_t;
   vec_t vecs[4];

   // One frame on the NREGS=2, DIV=1 instance; k counts clock edges from the start edge.
   task automatic run_small(input vec_t v, input int idx);
      logic [31:0] stream = '0;
      int nbits = 0, nbusy = 0, nlat = 0, nfd = 0, latfd = 0, k = 0;
      bit done = 1'b0;
      logic pl = 1'b0, ps = 1'b0;
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk); s_scan = 1'b1; s_qc = v.w0;
      @(posedge clk); k = 0;
      @(negedge clk); s_scan = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         if (s_busy) nbusy++;
         if (s_sclk && !ps) begin stream = {stream[30:0], s_sdata}; nbits++; end
         if (s_slatch) nlat++;
         if (s_fd) begin nfd++; if (pl) latfd++; end
         if (!s_busy && nfd > 0) done = 1'b1;
         ps = s_sclk; pl = s_slatch;
         s_qc = (s_sel == 4'd0) ? v.w0 : v.w1;
         // scramble every other cycle except the two CAPTURE cycles
         if (v.noise && k != 1 && k != 36 && k[0]) s_qc = ~s_qc;
         @(posedge clk); k++;
         @(negedge clk);
      end
      check({tag, "_finished"}, 32'(done), 32'd1);
      check({tag, "_stream"}, stream, v.stream);
      check({tag, "_nbits"}, nbits, 32'd32);
      check({tag, "_busy_cycles"}, nbusy, 32'd72);
      check({tag, "_latch_cycles"}, nlat, 32'd1);
      check({tag, "_done_pulses"}, nfd, 32'd1);
      check({tag, "_latch_then_done"}, latfd, 32'd1);
   endtask

   initial begin
      int fdc[3];
      int n, nl, nb, selbad, maxsel;
      logic [3:0] psel;
      bit found;

      vecs[0] = '{16'hA5C3, 16'h0001, 1'b0, 32'hA5C3_0001};
      vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 32'hFFFF_0000};
      vecs[2] = '{16'h8000, 16'h0001, 1'b1, 32'h8000_0001};
      vecs[3] = '{16'h1234, 16'hABCD, 1'b1, 32'h1234_ABCD};

      reset = 1'b1; d_scan = 1'b0; s_scan = 1'b0; t_scan = 1'b0; s_qc = '0;
      repeat (3) @(negedge clk);
      check("reset_d", 32'({d_sel, d_sclk, d_sdata, d_slatch, d_busy, d_fd}), 32'd0);
      check("reset_s", 32'({s_sel, s_sclk, s_sdata, s_slatch, s_busy, s_fd}), 32'd0);
      check("reset_t", 32'({t_sel, t_sclk, t_sdata, t_slatch, t_busy, t_fd}), 32'd0);
      reset = 1'b0; mon_on = 1'b1;

      // DIV=3 frame runs in the background while the table vectors go through u_s
      @(negedge clk); t_scan = 1'b1;
      @(negedge clk); t_scan = 1'b0;
      check("t_start_busy", 32'(t_busy), 32'd1);
      for (int i = 0; i < 4; i++) run_small(vecs[i], i);

      check("t_high_runs", t_nhi, 32'd32);
      check("t_low3_runs", t_lo3, 32'd30);
      check("t_bad_high_len", t_badhi, 32'd0);
      check("t_stream", t_stream, 32'hC0DE_3F01);
      check("t_back_idle", 32'(t_busy), 32'd0);

      // defaults, scan_en held: frame spacing and select walk
      n = 0; selbad = 0; maxsel = 0; psel = 4'd0;
      d_scan = 1'b1;
      for (int c = 0; c < 4000 && n < 3; c++) begin
         @(negedge clk);
         if (d_fd) begin fdc[n] = cyc; n++; end
         if (d_sel != psel) begin
            if (d_sel != ((psel + 4'd1) & 4'd7)) selbad++;
         end
         if (int'(d_sel) > maxsel) maxsel = int'(d_sel);
         psel = d_sel;
      end
      check("d_three_frames", n, 32'd3);
      check("d_period_1", (n == 3) ? fdc[1] - fdc[0] : -1, 32'd1053);
      check("d_period_2", (n == 3) ? fdc[2] - fdc[1] : -1, 32'd1053);
      check("d_sel_steps", selbad, 32'd0);
      check("d_sel_max", maxsel, 32'd7);

      // drop scan_en at cycle 100 of the next frame
      repeat (99) @(negedge clk);
      d_scan = 1'b0;
      n = 0; nl = 0;
      for (int c = 0; c < 1200 && n == 0; c++) begin
         @(negedge clk);
         if (d_slatch) nl++;
         if (d_fd) n++;
      end
      check("drop_frame_done", n, 32'd1);
      check("drop_latch_cycles", nl, 32'd4);
      nb = 0;
      repeat (30) begin @(negedge clk); if (d_busy) nb++; end
      check("drop_stays_idle", nb, 32'd0);

      // reset during SHIFT of register 3
      @(negedge clk); d_scan = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 1000 && !found; c++) begin
         @(negedge clk);
         if (d_sel == 4'd3 && d_sclk) found = 1'b1;
      end
      check("rst_reached_reg3", 32'(found), 32'd1);
      d_scan = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("rst_outputs_zero", 32'({d_sel, d_sclk, d_sdata, d_slatch, d_busy, d_fd}), 32'd0);
      reset = 1'b0;
      nl = 0; nb = 0;
      repeat (1200) begin @(negedge clk); if (d_slatch) nl++; if (d_busy) nb++; end
      check("rst_no_latch", nl, 32'd0);
      check("rst_no_busy", nb, 32'd0);

      check("sdata_hold_while_high", glitch, 32'd0);
      check("idle_outputs_zero", idlebad, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
